// File: rtl/env_pkg.sv
// Constants shared by the ADSR envelope generator and the envelope-controlled amplifier.
package env_pkg;

    localparam int                 ENV_FRAC_BITS = 14;
    localparam logic        [15:0] ENV_ONE       = 16'h4000;
    localparam logic signed [15:0] SAMPLE_MAX    = 16'sh7FFF;
    localparam logic signed [15:0] SAMPLE_MIN    = 16'sh8000;
    localparam int                 ROUND_BIAS    = 1 << (ENV_FRAC_BITS - 1);

    // Q1.15 sample times zero-extended Q2.14 gain.
    typedef logic signed [32:0] product_t;

endpackage

// File: rtl/env_sat_round.sv
// Rounds a Q1.15 x Q2.14 product back to Q1.15 (half toward +inf) and saturates to 16 bits.
module env_sat_round
    import env_pkg::*;
(
    input  product_t           product,
    output logic signed [15:0] sample
);

    product_t biased;
    product_t shifted;

    // NOTE: every output of this block is assigned on every path, so no latch can be inferred.
    always_comb begin
        biased  = product + product_t'(ROUND_BIAS);
        shifted = biased >>> ENV_FRAC_BITS;
        if (shifted > product_t'(SAMPLE_MAX)) begin
            sample = SAMPLE_MAX;
        end else if (shifted < product_t'(SAMPLE_MIN)) begin
            sample = SAMPLE_MIN;
        end else begin
            sample = shifted[15:0];
        end
    end

endmodule

// File: rtl/env_vca.sv
// Envelope-controlled amplifier: sample x Q2.14 envelope through a two-stage valid/ready pipe.
// Define VCA_ZERO_CROSS_EN to defer gain updates to zero crossings, bounded by ZC_TIMEOUT.
module env_vca
    import env_pkg::*;
#(
    parameter int ZC_TIMEOUT = 256
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_env,
    input  logic [15:0] i_sample,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [15:0] o_sample,
    output logic        o_valid,
    input  logic        i_ready
);

    if (ZC_TIMEOUT < 1 || ZC_TIMEOUT > 65535) begin : g_bad_timeout
        $error("env_vca: ZC_TIMEOUT must be in 1..65535");
    end

    logic               accept;
    logic               en;
    logic               gain_load;
    logic        [15:0] gain_q;
    logic        [15:0] gain_eff;
    logic               v1;
    logic               v2;
    product_t           product;
    product_t           p1;
    logic signed [15:0] rounded;

    assign o_ready = ~v2 | i_ready;
    assign en      = o_ready;
    assign accept  = i_valid & o_ready;
    assign o_valid = v2;

`ifdef VCA_ZERO_CROSS_EN
    localparam logic [15:0] ZC_LAST = 16'(ZC_TIMEOUT - 1);

    logic [15:0] zc_cnt;
    logic        first_q;
    logic        prev_neg;

    assign gain_load = accept & (first_q
                              | (i_sample == 16'h0000)
                              | (i_sample[15] != prev_neg)
                              | (zc_cnt == ZC_LAST));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            zc_cnt   <= '0;
            first_q  <= 1'b1;
            prev_neg <= 1'b0;
        end else if (accept) begin
            prev_neg <= i_sample[15];
            if (gain_load) begin
                zc_cnt  <= '0;
                first_q <= 1'b0;
            end else begin
                zc_cnt  <= zc_cnt + 16'd1;
            end
        end
    end
`else
    assign gain_load = accept;
`endif

    // The sample being accepted is scaled by the gain it updates, not the stale one.
    assign gain_eff = gain_load ? i_env : gain_q;
    assign product  = product_t'($signed(i_sample)) * product_t'($signed({1'b0, gain_eff}));

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            // NOTE: datapath registers are reset too, so o_sample reads 0 after reset.
            gain_q   <= '0;
            v1       <= 1'b0;
            v2       <= 1'b0;
            p1       <= '0;
            o_sample <= '0;
        end else begin
            if (gain_load) begin
                gain_q <= i_env;
            end
            if (en) begin
                v1 <= accept;
                v2 <= v1;
                if (accept) begin
                    p1 <= product;
                end
                if (v1) begin
                    o_sample <= rounded;
                end
            end
        end
    end

    env_sat_round u_sat_round (
        .product (p1),
        .sample  (rounded)
    );

endmodule
